reg_write_ctrl: RTL and testbench

//  Write-side counterpart of the register read-port steering. Decodes the writeback-stage IR into
//  the register-file write port: enable, address and data select, including jal->r31, setx->r30
//  and overflow->r30 status writes.

---
 rtl/reg_write_ctrl.sv | 172 +++++++++++++++++
 tb/tb_reg_write_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: writeback IR decode to the register-file write port plus a
// per-register pending-write scoreboard. Optional `REG_WRITE_BYPASS_EN.
module reg_write_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [31:0] issue_ir,
  input  logic [4:0]  read_a,
  input  logic [4:0]  read_b,
  input  logic        wb_valid,
  input  logic [31:0] wb_ir,
  input  logic [31:0] wb_alu,
  input  logic [31:0] wb_mem,
  input  logic [31:0] wb_pc1,
  input  logic        wb_ovf,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  function automatic logic ovf_op(input logic [31:0] ir);
    return ((ir[31:27] == OP_ALU) && (ir[6:3] == 4'd0))
        || (ir[31:27] == OP_ADDI);
  endfunction

  // add/sub/addi may land on r30 via overflow, so r30 is held too
  function automatic logic [31:0] res_mask(input logic [31:0] ir);
    logic [31:0] m;
    logic [4:0]  op;
    m  = '0;
    op = ir[31:27];
    unique case (1'b1)
      (op == OP_ALU),
      (op == OP_ADDI),
      (op == OP_LW):   m[ir[26:22]] = 1'b1;
      (op == OP_JAL):  m[31] = 1'b1;
      (op == OP_SETX): m[30] = 1'b1;
      default: ;
    endcase
    if (ovf_op(ir)) m[30] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic             wbv_q;
  logic [31:0]      wbir_q;

  logic        wr;
  logic [4:0]  dst;
  logic [31:0] dat;
  logic [4:0]  wop;
  logic        we_d;

  assign wop = wb_ir[31:27];

  always_comb begin
    wr  = 1'b0;
    dst = '0;
    dat = '0;
    unique case (1'b1)
      (wop == OP_ALU),
      (wop == OP_ADDI): begin
        wr  = 1'b1;
        dst = wb_ir[26:22];
        dat = wb_alu;
      end
      (wop == OP_LW): begin
        wr  = 1'b1;
        dst = wb_ir[26:22];
        dat = wb_mem;
      end
      (wop == OP_JAL): begin
        wr  = 1'b1;
        dst = 5'd31;
        dat = wb_pc1;
      end
      (wop == OP_SETX): begin
        wr  = 1'b1;
        dst = 5'd30;
        dat = {5'b0, wb_ir[26:0]};
      end
      default: ;
    endcase
    if (wb_ovf && ovf_op(wb_ir)) begin
      dst = 5'd30;
      if (wop == OP_ADDI) dat = 32'd2;
      else if (wb_ir[2])  dat = 32'd3;
      else                dat = 32'd1;
    end
  end

  assign we_d = wb_valid && wr && (dst != 5'd0);

  logic [31:0] set_i;
  logic [31:0] sat;
  logic        hit_a;
  logic        hit_b;
  logic        byp_a;
  logic        byp_b;

  assign set_i = res_mask(issue_ir);

  always_comb begin
    sat = '0;
    for (int i = 1; i < 32; i++) sat[i] = (cnt_q[i] == CMAX);
  end

  assign hit_a = (read_a != 5'd0) && (cnt_q[read_a] != '0);
  assign hit_b = (read_b != 5'd0) && (cnt_q[read_b] != '0);

`ifdef REG_WRITE_BYPASS_EN
  // last pending write is on the port now; the RF forwards it
  assign byp_a = rf_we && (rf_waddr == read_a) && (cnt_q[read_a] == CONE);
  assign byp_b = rf_we && (rf_waddr == read_b) && (cnt_q[read_b] == CONE);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  assign stall = issue_valid
              && ((hit_a && !byp_a) || (hit_b && !byp_b) || (|(set_i & sat)));

  logic [31:0] inc;
  logic [31:0] dec;

  assign inc = (issue_valid && !stall) ? set_i : '0;
  assign dec = wbv_q ? res_mask(wbir_q) : '0;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i] && (cnt_q[i] != CMAX))
        cnt_d[i] = cnt_q[i] + CONE;
      else if (dec[i] && !inc[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - CONE;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wbv_q    <= 1'b0;
      wbir_q   <= '0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      rf_we    <= we_d;
      rf_waddr <= we_d ? dst : 5'd0;
      rf_wdata <= we_d ? dat : 32'd0;
      wbv_q    <= wb_valid;
      wbir_q   <= wb_ir;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb_reg_write_ctrl: directed + random stimulus against an abstract
// scoreboard model; write-port results checked by a separate monitor.
module tb_reg_write_ctrl;

  localparam int MAX = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_ir = '0;
  logic [4:0]  read_a = '0;
  logic [4:0]  read_b = '0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_ir = '0;
  logic [31:0] wb_alu = '0;
  logic [31:0] wb_mem = '0;
  logic [31:0] wb_pc1 = '0;
  logic        wb_ovf = 1'b0;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  reg_write_ctrl #(.CNT_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ir(issue_ir),
    .read_a(read_a), .read_b(read_b),
    .wb_valid(wb_valid), .wb_ir(wb_ir),
    .wb_alu(wb_alu), .wb_mem(wb_mem), .wb_pc1(wb_pc1),
    .wb_ovf(wb_ovf), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clock = ~clock;

  int ecnt = 0;
  always @(posedge clock) ecnt <= ecnt + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] inflight[$];
  int          cnt[32];
  logic [31:0] pend;
  logic        cur_we;
  logic [4:0]  cur_addr;
  logic        last_stall;
  logic        mon_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
`ifdef REG_WRITE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  localparam logic [4:0] NW [6] = '{5'd7, 5'd1, 5'd4, 5'd2, 5'd6, 5'd22};

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, ecnt);
    end
  endtask

  // registers an instruction holds in the scoreboard from issue to retire
  function automatic logic [31:0] rset(input logic [31:0] ir);
    logic [31:0] s;
    logic [4:0]  op;
    s  = '0;
    op = ir[31:27];
    if (op == 5'd0 || op == 5'd5 || op == 5'd8) s[ir[26:22]] = 1'b1;
    if ((op == 5'd0 && ir[6:2] <= 5'd1) || op == 5'd5) s[30] = 1'b1;
    if (op == 5'd3)  s[31] = 1'b1;
    if (op == 5'd21) s[30] = 1'b1;
    s[0] = 1'b0;
    return s;
  endfunction

  function automatic void wexp(input logic [31:0] ir, input logic ovf,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [31:0] pc1, output logic we,
                               output logic [4:0] a, output logic [31:0] d);
    logic [4:0] op;
    op = ir[31:27];
    we = 1'b1;
    a  = ir[26:22];
    d  = alu;
    case (op)
      5'd0: if (ovf && ir[6:2] <= 5'd1) begin
        a = 5'd30;
        d = (ir[6:2] == 5'd0) ? 32'd1 : 32'd3;
      end
      5'd5: if (ovf) begin
        a = 5'd30;
        d = 32'd2;
      end
      5'd8:  d = mem;
      5'd3:  begin a = 5'd31; d = pc1; end
      5'd21: begin a = 5'd30; d = {5'b0, ir[26:0]}; end
      default: we = 1'b0;
    endcase
    if (a == 5'd0) we = 1'b0;
  endfunction

  function automatic logic busy(input logic [4:0] r);
    logic b;
    if (r == 5'd0) return 1'b0;
    b = (cnt[r] != 0);
    if (BYP && cur_we && cur_addr == r && cnt[r] == 1) b = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] mk_alu(input logic [4:0] sub,
                                         input logic [4:0] rd);
    return {5'd0, rd, 15'($urandom), sub, 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op,
                                       input logic [4:0] rd);
    return {op, rd, 22'($urandom)};
  endfunction

  function automatic logic [31:0] mk_nw();
    return {NW[$urandom % 6], 27'($urandom)};
  endfunction

  function automatic logic [4:0] rand_rd();
    int r;
    r = int'($urandom % 10);
    if (r < 8) return 5'(r + 1);
    return (r == 8) ? 5'd30 : 5'd31;
  endfunction

  function automatic logic [31:0] rand_ir();
    case ($urandom % 8)
      0: return mk_alu(5'd0, rand_rd());
      1: return mk_alu(5'd1, rand_rd());
      2: return mk_alu(5'($urandom_range(2, 31)), rand_rd());
      3: return mk_i(5'd5, rand_rd());
      4: return mk_i(5'd8, rand_rd());
      5: return mk_i(5'd3, 5'($urandom));
      6: return {5'd21, 27'($urandom)};
      default: return mk_nw();
    endcase
  endfunction

  // one clock: check stall, advance, update the model, push expectations
  task automatic tick();
    logic        ms;
    logic [31:0] s;
    logic [31:0] inc;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    #1;
    ms = 1'b0;
    if (issue_valid) begin
      if (busy(read_a) || busy(read_b)) ms = 1'b1;
      s = rset(issue_ir);
      for (int i = 1; i < 32; i++) if (s[i] && cnt[i] == MAX) ms = 1'b1;
    end
    chk("stall", {31'b0, stall}, {31'b0, ms});
    last_stall = stall;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) cnt[i] = 0;
      pend   = '0;
      cur_we = 1'b0;
      inflight.delete();
    end else begin
      inc = (issue_valid && !ms) ? rset(issue_ir) : '0;
      for (int i = 1; i < 32; i++) begin
        cnt[i] = cnt[i] + int'(inc[i]) - int'(pend[i]);
        if (cnt[i] < 0) cnt[i] = 0;
        if (cnt[i] > MAX) cnt[i] = MAX;
      end
      if (issue_valid && !ms) inflight.push_back(issue_ir);
      pend = wb_valid ? rset(wb_ir) : '0;
      wexp(wb_ir, wb_ovf, wb_alu, wb_mem, wb_pc1, we, a, d);
      we       = we && wb_valid;
      cur_we   = we;
      cur_addr = a;
      if (we) expq.push_back('{ecnt, a, d});
    end
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
    wb_ovf      = 1'b0;
    read_a      = '0;
    read_b      = '0;
  endtask

  task automatic wb_front(input logic ovf);
    if (inflight.size() > 0) begin
      wb_valid = 1'b1;
      wb_ir    = inflight.pop_front();
      wb_alu   = $urandom;
      wb_mem   = $urandom;
      wb_pc1   = $urandom;
      wb_ovf   = ovf;
    end
  endtask

  task automatic drain();
    while (inflight.size() > 0) begin
      wb_front(1'b0);
      tick();
    end
    tick();
    tick();
  endtask

  task automatic issue_rd(input logic [31:0] ir, input logic [4:0] ra,
                          input logic [4:0] rb);
    issue_valid = 1'b1;
    issue_ir    = ir;
    read_a      = ra;
    read_b      = rb;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (expq.size() > 0 && expq[0].cyc == ecnt) begin
        exp_t e;
        e = expq.pop_front();
        chk("rf_we", {31'b0, rf_we}, 32'd1);
        chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.a});
        chk("rf_wdata", rf_wdata, e.d);
      end else begin
        chk("rf_we_idle", {31'b0, rf_we}, 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    pend   = '0;
    cur_we = 1'b0;
    cur_addr = '0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    repeat (2) begin
      reset_n  = 1'b0;
      wb_valid = 1'b1;
      wb_ir    = mk_i(5'd3, 5'd0);
      wb_pc1   = 32'h80;
      tick();
    end
    chk("rst_we", {31'b0, rf_we}, 32'd0);
    chk("rst_waddr", {27'b0, rf_waddr}, 32'd0);
    reset_n = 1'b1;
    issue_rd(mk_i(5'd7, 5'd1), 5'd1, 5'd2);
    tick();
    chk("rst_stall", {31'b0, last_stall}, 32'd0);
    drain();

    issue_rd(mk_alu(5'd0, 5'd3), 5'd1, 5'd2);
    tick();
    issue_rd(mk_i(5'd7, 5'd0), 5'd3, 5'd0);
    tick();
    chk("raw_stall", {31'b0, last_stall}, 32'd1);
    wb_front(1'b0);
    issue_rd(mk_i(5'd7, 5'd0), 5'd3, 5'd0);
    tick();
    issue_rd(mk_i(5'd7, 5'd0), 5'd3, 5'd0);
    tick();
    chk("wecyc_stall", {31'b0, last_stall}, {31'b0, !BYP});
    issue_rd(mk_i(5'd7, 5'd0), 5'd3, 5'd0);
    tick();
    chk("after_stall", {31'b0, last_stall}, 32'd0);
    drain();

    issue_rd(mk_alu(5'd0, 5'd5), 5'd0, 5'd0);
    tick();
    wb_front(1'b1);
    tick();
    chk("ovf_addr", {27'b0, rf_waddr}, 32'd30);
    chk("ovf_data", rf_wdata, 32'd1);
    issue_rd(mk_i(5'd7, 5'd0), 5'd5, 5'd30);
    tick();
    chk("ovf_busy", {31'b0, last_stall}, 32'd1);
    issue_rd(mk_i(5'd7, 5'd0), 5'd5, 5'd30);
    tick();
    chk("ovf_free", {31'b0, last_stall}, 32'd0);
    drain();

    issue_rd(mk_i(5'd3, 5'd0), 5'd0, 5'd0);
    tick();
    wb_front(1'b0);
    wb_pc1 = 32'h40;
    tick();
    chk("jal_addr", {27'b0, rf_waddr}, 32'd31);
    chk("jal_data", rf_wdata, 32'h40);
    issue_rd({5'd21, 27'h123}, 5'd0, 5'd0);
    tick();
    wb_front(1'b0);
    tick();
    chk("setx_addr", {27'b0, rf_waddr}, 32'd30);
    chk("setx_data", rf_wdata, 32'h123);
    drain();

    issue_rd(mk_i(5'd5, 5'd0), 5'd0, 5'd0);
    tick();
    wb_front(1'b0);
    tick();
    chk("r0_we", {31'b0, rf_we}, 32'd0);
    foreach (NW[k]) begin
      wb_valid = 1'b1;
      wb_ir    = mk_i(NW[k], 5'd9);
      tick();
      chk("nw_we", {31'b0, rf_we}, 32'd0);
    end
    drain();

    issue_rd(mk_i(5'd8, 5'd7), 5'd0, 5'd0);
    tick();
    wb_front(1'b0);
    tick();
    issue_rd(mk_i(5'd8, 5'd7), 5'd0, 5'd0);
    tick();
    issue_rd(mk_i(5'd7, 5'd0), 5'd7, 5'd0);
    tick();
    chk("lw7_held", {31'b0, last_stall}, 32'd1);
    drain();
    issue_rd(mk_i(5'd7, 5'd0), 5'd7, 5'd0);
    tick();
    chk("lw7_free", {31'b0, last_stall}, 32'd0);
    drain();

    for (int k = 0; k < 4; k++) begin
      issue_rd(mk_i(5'd8, 5'd9), 5'd0, 5'd0);
      tick();
      chk("sat_stall", {31'b0, last_stall}, {31'b0, (k == 3)});
    end
    drain();

    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom % 200) != 0;
      if (inflight.size() > 4 || (inflight.size() > 0 && $urandom % 5 < 3))
        wb_front(($urandom % 4) == 0);
      else if ($urandom % 8 == 0) begin
        wb_valid = 1'b1;
        wb_ir    = mk_nw();
        wb_ovf   = 1'($urandom);
      end
      issue_valid = ($urandom % 3) != 0;
      issue_ir    = rand_ir();
      read_a      = ($urandom % 4 == 0) ? rand_rd() : 5'($urandom % 10);
      read_b      = ($urandom % 4 == 0) ? rand_rd() : 5'($urandom % 10);
      tick();
    end
    reset_n = 1'b1;
    drain();
    tick();
    chk("expq_empty", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
